// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 responder backed by a byte-lane SRAM model.
// Write (AW/W/B) and read (AR/R) paths are independent FSMs with one burst in flight each.
// Optional feature macro: AXI4_SLAVE_DECERR_EN. When defined, bursts starting outside
// [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) are fully handshaken but writes are dropped,
// BRESP is DECERR and reads return zero. When undefined, addresses wrap modulo DEPTH.
// Wrapping-burst arithmetic assumes ADDR_W >= 16.
module axi4_sram_slave #(
  parameter int                ID_W_W    = 4,
  parameter int                ID_R_W    = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // write address channel
  input  logic [ID_W_W-1:0]   AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic [1:0]          AWLOCK,
  input  logic [3:0]          AWCACHE,
  input  logic [2:0]          AWPORT,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data channel
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response channel
  output logic [ID_W_W-1:0]   BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address channel
  input  logic [ID_R_W-1:0]   ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic [1:0]          ARLOCK,
  input  logic [3:0]          ARCACHE,
  input  logic [2:0]          ARPORT,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data channel
  output logic [ID_R_W-1:0]   RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [DATA_W/8-1:0] RSTRB,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LOG2_B = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Byte address -> memory word index; upper bits drop out, giving the modulo-DEPTH wrap.
  function automatic logic [IDX_W-1:0] f_word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LOG2_B);
  endfunction

  // Address of the following beat. Oversized beats are clamped to the bus width.
  // WRAP keeps the bits above the (LEN+1)*2^SIZE window and increments inside it.
  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0]        len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
    logic [2:0]        eff;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] sum;
    eff  = (size > 3'(LOG2_B)) ? 3'(LOG2_B) : size;
    inc  = ADDR_W'(1) << eff;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << eff) - ADDR_W'(1);
    sum  = a + inc;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (sum & mask);
      default: return sum;
    endcase
  endfunction

  logic              r_live;
  logic [1:0]        r_w_state;
  logic [ID_W_W-1:0] r_w_id;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_len;
  logic [2:0]        r_w_size;
  logic [1:0]        r_w_burst;
  logic [7:0]        r_w_cnt;
  logic              r_w_err;
  logic [0:0]        r_r_state;
  logic [ID_R_W-1:0] r_r_id;
  logic [ADDR_W-1:0] r_r_addr;
  logic [7:0]        r_r_len;
  logic [2:0]        r_r_size;
  logic [1:0]        r_r_burst;
  logic [7:0]        r_r_cnt;
  logic              r_r_err;

  logic              w_aw_hs;
  logic              w_ar_hs;
  logic              w_aw_err;
  logic              w_ar_err;
  logic              w_r_last;
  logic              w_mem_we;
  logic              w_r_load;
  logic [IDX_W-1:0]  w_w_idx;
  logic [IDX_W-1:0]  w_r_idx;
  logic [ADDR_W-1:0] w_w_next_addr;
  logic [ADDR_W-1:0] w_r_next_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  // Sideband qualifiers are accepted but carry no meaning for this memory.
  assign w_unused = ^{AWLOCK, AWCACHE, AWPORT, WLAST, ARLOCK, ARCACHE, ARPORT};

`ifdef AXI4_SLAVE_DECERR_EN
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * BYTES);
  assign w_aw_err = (AWADDR < BASE_ADDR) || ({1'b0, AWADDR} >= LIMIT);
  assign w_ar_err = (ARADDR < BASE_ADDR) || ({1'b0, ARADDR} >= LIMIT);
`else
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
`endif

  assign AWREADY  = r_live && (r_w_state == W_IDLE);
  assign WREADY   = (r_w_state == W_DATA);
  assign BVALID   = (r_w_state == W_RESP);
  assign BID      = BVALID ? r_w_id : '0;
  assign BRESP    = (BVALID && r_w_err) ? 2'b11 : 2'b00;

  assign ARREADY  = r_live && (r_r_state == R_IDLE);
  assign RVALID   = (r_r_state == R_DATA);
  assign w_r_last = (r_r_cnt == r_r_len);
  assign RLAST    = RVALID && w_r_last;
  assign RID      = RVALID ? r_r_id : '0;
  assign RSTRB    = {BYTES{RVALID}};
  assign RDATA    = (RVALID && !r_r_err) ? w_rdata : '0;

  assign w_aw_hs       = AWVALID && AWREADY;
  assign w_ar_hs       = ARVALID && ARREADY;
  assign w_w_next_addr = f_next_addr(r_w_addr, r_w_len, r_w_size, r_w_burst);
  assign w_r_next_addr = f_next_addr(r_r_addr, r_r_len, r_r_size, r_r_burst);
  assign w_mem_we      = (r_w_state == W_DATA) && WVALID && !r_w_err;
  assign w_w_idx       = f_word_idx(r_w_addr);
  // The read register is refilled on the AR handshake and on every accepted non-last beat,
  // so RDATA is ready the cycle RVALID rises and never changes while the beat is stalled.
  assign w_r_load      = w_ar_hs || (RVALID && RREADY && !w_r_last);
  assign w_r_idx       = w_ar_hs ? f_word_idx(ARADDR) : f_word_idx(w_r_next_addr);

  // Readies stay low during reset and rise on the first edge after release
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Write FSM: capture AW, take beats until the LEN-th, then hold B until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_w_state <= W_IDLE;
      r_w_id    <= '0;
      r_w_addr  <= '0;
      r_w_len   <= '0;
      r_w_size  <= '0;
      r_w_burst <= '0;
      r_w_cnt   <= '0;
      r_w_err   <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_w_id    <= AWID;
            r_w_addr  <= AWADDR;
            r_w_len   <= AWLEN;
            r_w_size  <= AWSIZE;
            r_w_burst <= AWBURST;
            r_w_cnt   <= '0;
            r_w_err   <= w_aw_err;
            r_w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            r_w_addr <= w_w_next_addr;
            if (r_w_cnt == r_w_len) r_w_state <= W_RESP;
            else                    r_w_cnt   <= r_w_cnt + 8'd1;
          end
        end
        W_RESP: begin
          if (BREADY) r_w_state <= W_IDLE;
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture AR, present beats until the LEN-th is accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_r_state <= R_IDLE;
      r_r_id    <= '0;
      r_r_addr  <= '0;
      r_r_len   <= '0;
      r_r_size  <= '0;
      r_r_burst <= '0;
      r_r_cnt   <= '0;
      r_r_err   <= 1'b0;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_r_id    <= ARID;
            r_r_addr  <= ARADDR;
            r_r_len   <= ARLEN;
            r_r_size  <= ARSIZE;
            r_r_burst <= ARBURST;
            r_r_cnt   <= '0;
            r_r_err   <= w_ar_err;
            r_r_state <= R_DATA;
          end
        end
        default: begin
          if (RREADY) begin
            r_r_addr <= w_r_next_addr;
            if (w_r_last) r_r_state <= R_IDLE;
            else          r_r_cnt   <= r_r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // One RAM per byte lane so WSTRB maps directly onto per-lane write enables
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd_byte;

      // Lane write plus registered read; a same-edge read sees the old contents
      always_ff @(posedge ACLK) begin
        if (w_mem_we && WSTRB[gi]) r_mem[w_w_idx] <= WDATA[gi*8 +: 8];
        if (w_r_load)              r_rd_byte      <= r_mem[w_r_idx];
      end

      assign w_rdata[gi*8 +: 8] = r_rd_byte;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Randomized self-checking bench for axi4_sram_slave (DATA_W=32, DEPTH=64, BASE_ADDR=0).
// Honours AXI4_SLAVE_DECERR_EN when the build defines it.
module tb_axi4_sram_slave;

  localparam int DEPTH = 64;
`ifdef AXI4_SLAVE_DECERR_EN
  localparam bit DECERR_ON = 1'b1;
`else
  localparam bit DECERR_ON = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPORT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPORT;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [3:0]  RSTRB;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi4_sram_slave #(
    .ID_W_W(4), .ID_R_W(4), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPORT(AWPORT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RSTRB(RSTRB), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word index touched by beat i of a burst, from the burst rules in plain arithmetic
  function automatic int beat_idx(input logic [31:0] a, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst, input int i);
    longint sb, span, lower, ba;
    sb   = 64'd1 << ((size > 3'd2) ? 2 : int'(size));
    span = (longint'(len) + 1) * sb;
    case (burst)
      2'b00: ba = longint'(a);
      2'b10: begin
        lower = longint'(a) - (longint'(a) % span);
        ba    = lower + ((longint'(a) - lower + i * sb) % span);
      end
      default: ba = longint'(a) + i * sb;
    endcase
    return int'((ba >> 2) % DEPTH);
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return DECERR_ON && (a >= 32'h100);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bstall);
    int   cyc;
    int   gap;
    int   idx;
    logic hs;
    logic err;
    err = is_err(addr);
    $display("WR id=%0h addr=%08h len=%0d size=%0d burst=%0d bstall=%0d", id, addr, len, size, burst, bstall);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge ACLK); hs = AWREADY;
      @(posedge ACLK); #1; cyc++;
    end
    AWVALID = 1'b0;
    check("aw_handshake", hs, 1);
    for (int i = 0; i <= int'(len); i++) begin
      gap = (i > 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
      WVALID = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge ACLK); #1;
      end
      WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == int'(len));
      @(negedge ACLK); check("w_ready", WREADY, 1);
      @(posedge ACLK); #1;
      if (!err) begin
        idx = beat_idx(addr, len, size, burst, i);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mem_model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b0;
    for (int s = 0; s < bstall; s++) begin
      @(negedge ACLK);
      check("b_hold_valid", BVALID, 1);
      check("b_hold_id", BID, id);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    check("b_valid", BVALID, 1);
    check("b_id", BID, id);
    check("b_resp", BRESP, err ? 2'b11 : 2'b00);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK); check("b_done", BVALID, 0);
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_n);
    int          cyc;
    int          stall;
    logic        hs;
    logic        err;
    logic [31:0] exp;
    err = is_err(addr);
    $display("RD id=%0h addr=%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    RREADY = 1'b0;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge ACLK); hs = ARREADY;
      @(posedge ACLK); #1; cyc++;
    end
    ARVALID = 1'b0;
    check("ar_handshake", hs, 1);
    for (int i = 0; i <= int'(len); i++) begin
      exp   = err ? 32'h0 : mem_model[beat_idx(addr, len, size, burst, i)];
      stall = (i == stall_beat) ? stall_n : (($urandom_range(0, 3) == 0) ? 1 : 0);
      RREADY = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge ACLK);
        check("r_hold_valid", RVALID, 1);
        check("r_hold_data", RDATA, exp);
        check("r_hold_last", RLAST, i == int'(len));
        @(posedge ACLK); #1;
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      check("r_valid", RVALID, 1);
      check("r_data", RDATA, exp);
      check("r_last", RLAST, i == int'(len));
      check("r_id", RID, id);
      if (i == 0) check("r_strb", RSTRB, 4'hF);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    @(negedge ACLK); check("r_done", RVALID, 0);
    @(posedge ACLK); #1;
  endtask

  // Hard stop in case a handshake sequence ever loses the clock
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] sz;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [31:0] ad;
    int sb;

    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWLOCK = '0; AWCACHE = '0; AWPORT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARLOCK = '0; ARCACHE = '0; ARPORT = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state and release timing
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_readies", {AWREADY, ARREADY}, 2'b00);
    check("rst_valids", {WREADY, BVALID, RVALID, RLAST}, 4'b0000);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rel_ready_early", {AWREADY, ARREADY}, 2'b00);
    @(posedge ACLK); #1;
    check("rel_ready_edge", {AWREADY, ARREADY}, 2'b11);

    // Fill the whole memory so every later read has a known value
    for (int i = 0; i < DEPTH; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF;
    end
    do_write(4'h1, 32'h0, 8'(DEPTH - 1), 3'd2, 2'b01, 0);

    // INCR write of 1..4 at 0x40 and read-back
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF;
    end
    do_write(4'h5, 32'h40, 8'd3, 3'd2, 2'b01, 0);
    do_read(4'h6, 32'h40, 8'd3, 3'd2, 2'b01, -1, 0);

    // Byte strobes over a full word
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(4'h2, 32'h80, 8'd0, 3'd2, 2'b01, 0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(4'h3, 32'h80, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'h4, 32'h80, 8'd0, 3'd2, 2'b01, -1, 0);
    check("strobe_model", mem_model[32], 32'hFF22_FF44);

    // WRAP read starting mid-window
    do_read(4'h7, 32'h08, 8'd3, 3'd2, 2'b10, -1, 0);

    // Backpressure on R and B
    do_read(4'h8, 32'h10, 8'd5, 3'd2, 2'b01, 2, 5);
    for (int i = 0; i < 2; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF;
    end
    do_write(4'h9, 32'h20, 8'd1, 3'd2, 2'b01, 3);

    // One word past the end of the memory
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(4'hA, 32'h100, 8'd0, 3'd2, 2'b01, 0);
    do_read(4'hB, 32'h0, 8'd0, 3'd2, 2'b01, -1, 0);
    do_read(4'hC, 32'h100, 8'd0, 3'd2, 2'b01, -1, 0);

    // Randomized bursts of every type and size
    for (int t = 0; t < 40; t++) begin
      bt = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 3));
      ln = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      sb = 1 << ((sz > 3'd2) ? 2 : int'(sz));
      ad = 32'($urandom_range(0, 255)) & ~32'(sb - 1);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(ln); i++) begin
          wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
        end
        do_write(4'($urandom), ad, ln, sz, bt, $urandom_range(0, 3));
      end else begin
        do_read(4'($urandom), ad, ln, sz, bt, -1, 0);
      end
    end

    // Reset in the middle of open write and read bursts
    AWID = 4'h3; AWADDR = 32'h0; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 4'h4; ARADDR = 32'h0; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    RREADY = 1'b0;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    check("mid_wready", WREADY, 1);
    check("mid_rvalid", RVALID, 1);
    #2;
    ARESET = 1'b1;
    #1;
    check("async_rst_ctl", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST}, 8'h00);
    check("async_rst_data", {RID, BID, RDATA, RSTRB}, 44'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst2_ready_early", {AWREADY, ARREADY}, 2'b00);
    @(posedge ACLK); #1;
    check("rst2_ready_edge", {AWREADY, ARREADY, WREADY, RVALID}, 4'b1100);

    // Memory survives reset
    do_read(4'hD, 32'h0, 8'd7, 3'd2, 2'b01, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
